// File: rtl/clock_step_controller_pkg.sv
// ---------------------------------------------------------------------------
// clock_step_controller_pkg
// Shared definitions for the front-panel clock step controller: the step FSM
// state encodings and the default timing parameters used by both the top
// level and the button debouncer.
// ---------------------------------------------------------------------------
package clock_step_controller_pkg;

  // Default number of consecutive clk cycles a synchronized button level
  // must hold before the debounced level follows it.
  localparam int DEFAULT_DEBOUNCE_CYCLES = 4;

  // Default width of each adv_clk high pulse, and of the low gap after it.
  localparam int DEFAULT_PULSE_CYCLES = 2;

  // Step FSM states; encodings are fixed so other blocks can decode them.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2
  } stepState_t;

endpackage

// File: rtl/clock_step_controller_button_debouncer.sv
// ---------------------------------------------------------------------------
// button_debouncer
// Cleans one raw front-panel push button: two-flop synchronizer, stability
// counter, and a registered rising-edge detector on the debounced level.
//
// Ports:
//   clk      in   free-running oscillator clock
//   rst      in   synchronous reset, active-high
//   i_raw    in   raw, asynchronous, bouncy button level
//   o_press  out  one-cycle pulse for each accepted press (0->1 only)
// ---------------------------------------------------------------------------
module button_debouncer
  import clock_step_controller_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic             r_levelDly;
  logic             r_press;
  logic [CNT_W-1:0] r_count;

  // Synchronize the raw level, then let the debounced level follow it only
  // after it has disagreed for DEBOUNCE_CYCLES cycles in a row. Any return to
  // agreement restarts the count, so short glitches never get through. The
  // press pulse is taken from the debounced level and its one-cycle-old copy,
  // which keeps the output registered and ignores releases.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_level    <= 1'b0;
      r_levelDly <= 1'b0;
      r_press    <= 1'b0;
      r_count    <= '0;
    end else begin
      r_sync1    <= i_raw;
      r_sync2    <= r_sync1;
      r_levelDly <= r_level;
      r_press    <= r_level & ~r_levelDly;
      if (r_sync2 == r_level) begin
        r_count <= '0;
      end else if (r_count == CNT_LAST) begin
        r_level <= r_sync2;
        r_count <= '0;
      end else begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/clock_step_controller.sv
// ---------------------------------------------------------------------------
// clock_step_controller
// Produces the manual_en, adv_clk and halt levels consumed by the processor's
// clock gating module, from three bouncy front-panel buttons and the control
// unit's HLT request. All outputs come straight from flops.
//
// Ports:
//   clk         in   free-running oscillator clock
//   rst         in   synchronous reset, active-high
//   btn_mode    in   raw button; each accepted press toggles manual mode
//   btn_step    in   raw button; each accepted press requests one step pulse
//   btn_resume  in   raw button; each accepted press clears the halt latch
//   hlt_in      in   synchronous halt request from the control unit
//   manual_en   out  1 = manual single-step mode, 0 = free-run
//   adv_clk     out  manual step pulse
//   halt        out  latched halt
//   step_busy   out  high while the step FSM is in PULSE or GAP
// ---------------------------------------------------------------------------
module clock_step_controller
  import clock_step_controller_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int PULSE_CYCLES    = DEFAULT_PULSE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_mode,
  input  logic btn_step,
  input  logic btn_resume,
  input  logic hlt_in,
  output logic manual_en,
  output logic adv_clk,
  output logic halt,
  output logic step_busy
);

  localparam int CNT_W = $clog2(PULSE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PULSE_CYCLES - 1);

  logic w_modePress;
  logic w_stepPress;
  logic w_resumePress;

  stepState_t       r_state;
  logic [CNT_W-1:0] r_count;
  logic             r_manualEn;
  logic             r_halt;
  logic             r_advClk;
  logic             r_stepBusy;

  // Each button gets an identical clean-up path.
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_modeDeb (
    .clk     (clk),
    .rst     (rst),
    .i_raw   (btn_mode),
    .o_press (w_modePress)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_stepDeb (
    .clk     (clk),
    .rst     (rst),
    .i_raw   (btn_step),
    .o_press (w_stepPress)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_resumeDeb (
    .clk     (clk),
    .rst     (rst),
    .i_raw   (btn_resume),
    .o_press (w_resumePress)
  );

  // Mode toggle, halt latch and step FSM share one block so every decision
  // sees the same pre-edge values: a step press coinciding with a mode press
  // or an HLT request is judged on the old manual_en/halt. The halt latch
  // gives set priority over clear, so a resume cannot race past HLT. In PULSE
  // or GAP the FSM bails out to IDLE as soon as manual mode drops or halt is
  // latched, forcing adv_clk low rather than letting a pulse finish late.
  // Presses arriving outside IDLE are simply ignored, never queued.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_manualEn <= 1'b0;
      r_halt     <= 1'b0;
      r_state    <= ST_IDLE;
      r_count    <= '0;
      r_advClk   <= 1'b0;
      r_stepBusy <= 1'b0;
    end else begin
      if (w_modePress) begin
        r_manualEn <= ~r_manualEn;
      end

      if (hlt_in) begin
        r_halt <= 1'b1;
      end else if (w_resumePress) begin
        r_halt <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_stepPress && r_manualEn && !r_halt) begin
            r_state    <= ST_PULSE;
            r_count    <= '0;
            r_advClk   <= 1'b1;
            r_stepBusy <= 1'b1;
          end
        end
        ST_PULSE: begin
          if (!r_manualEn || r_halt) begin
            r_state    <= ST_IDLE;
            r_advClk   <= 1'b0;
            r_stepBusy <= 1'b0;
          end else if (r_count == CNT_LAST) begin
            r_state  <= ST_GAP;
            r_count  <= '0;
            r_advClk <= 1'b0;
          end else begin
            r_count <= r_count + 1'b1;
          end
        end
        ST_GAP: begin
          if (!r_manualEn || r_halt || (r_count == CNT_LAST)) begin
            r_state    <= ST_IDLE;
            r_advClk   <= 1'b0;
            r_stepBusy <= 1'b0;
          end else begin
            r_count <= r_count + 1'b1;
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_advClk   <= 1'b0;
          r_stepBusy <= 1'b0;
        end
      endcase
    end
  end

  assign manual_en = r_manualEn;
  assign adv_clk   = r_advClk;
  assign halt      = r_halt;
  assign step_busy = r_stepBusy;

endmodule
